constraint_assign_gen: RTL

// - Producer side of the constraint-check interface: generates pseudo-random candidate assignments for
//   NUM_VARS solver variables, presents them to a generated constraint checker, samples its x verdict,
//   and streams accepted assignments out over a valid/ready channel.
// - Sits between solver control (start/seed/count) and the checker; replaces software rejection sampling.

---
 rtl/constraint_assign_gen_pkg.sv | 31 +++
 rtl/constraint_assign_gen_lfsr64.sv | 30 +++
 rtl/constraint_assign_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/constraint_assign_gen_pkg.sv
// Shared types and constants for the constraint-assignment generator:
// FSM state encoding, LFSR constants and the per-variable width mask helper.
package constraint_gen_pkg;

  localparam int VAR_W         = 64;
  localparam int WIDTH_FIELD_W = 7;

  localparam logic [63:0] DEFAULT_SEED = 64'hACE1_0F0F_1234_5679;
  // Galois toggle mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form)
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    CHECK,
    EMIT,
    DONE,
    FAIL
  } state_t;

  typedef logic [WIDTH_FIELD_W-1:0] var_width_t;

  // Low w bits set; widths at or above VAR_W keep the whole slot.
  function automatic logic [VAR_W-1:0] width_mask(input var_width_t w);
    if (w >= var_width_t'(VAR_W)) begin
      return '1;
    end
    return (VAR_W'(1) << w) - VAR_W'(1);
  endfunction

endpackage

// File: rtl/constraint_assign_gen_lfsr64.sv
// 64-bit Galois LFSR used as the candidate source. A zero seed is replaced by
// the reset seed so the register can never lock up in the all-zero state.
module lfsr64
  import constraint_gen_pkg::*;
#(
  parameter logic [63:0] RESET_SEED = 64'hACE1_0F0F_1234_5679
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [63:0] seed,
  output logic [63:0] state
);

  logic [63:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
    end else if (load) begin
      state_q <= (seed == 64'd0) ? RESET_SEED : seed;
    end else if (step) begin
      state_q <= (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 64'd0);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/constraint_assign_gen.sv
// Rejection-sampling front end: fills NUM_VARS variable slots from an LFSR,
// presents the candidate to a constraint checker and streams accepted ones out.
module constraint_assign_gen #(
  parameter int                       NUM_VARS     = 20,
  parameter int                       VAR_W        = 64,
  parameter logic [NUM_VARS*7-1:0]    VAR_WIDTHS   = {NUM_VARS{7'd64}},
  parameter int                       CHK_LAT      = 1,
  parameter int                       MAX_TRIES    = 1024,
  parameter logic [63:0]              DEFAULT_SEED = 64'hACE1_0F0F_1234_5679
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 req_count,
  input  logic                        seed_load,
  input  logic [63:0]                 seed,
  output logic [NUM_VARS*VAR_W-1:0]   cand_vars,
  output logic                        cand_valid,
  input  logic                        chk_x,
  output logic                        sol_valid,
  input  logic                        sol_ready,
  output logic [NUM_VARS*VAR_W-1:0]   sol_vars,
  output logic [15:0]                 sol_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        fail,
  output logic [31:0]                 tries
);

  import constraint_gen_pkg::*;

  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int LAT_W = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          gen_idx_q;
  logic [LAT_W-1:0]          lat_cnt_q;
  logic [TRY_W-1:0]          sol_tries_q;
  logic [15:0]               req_count_q;
  logic [15:0]               sol_idx_q;
  logic [31:0]               tries_q;
  logic [VAR_W-1:0]          cand_q [NUM_VARS];
  logic [NUM_VARS*VAR_W-1:0] cand_flat;
  logic [NUM_VARS*VAR_W-1:0] sol_vars_q;

  logic [63:0]               lfsr_word;
  logic [63:0]               mask_full;
  var_width_t                gen_width;
  logic [VAR_W-1:0]          gen_word;
  logic                      gen_last, chk_last, last_sol, lfsr_load, lfsr_step;

  lfsr64 #(
    .RESET_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .load  (lfsr_load),
    .seed  (seed),
    .state (lfsr_word)
  );

  assign lfsr_load = seed_load && (state_q == IDLE);
  assign lfsr_step = (state_q == GEN);

  assign gen_width = VAR_WIDTHS[int'(gen_idx_q)*WIDTH_FIELD_W +: WIDTH_FIELD_W];
  assign mask_full = width_mask(gen_width);
  assign gen_word  = lfsr_word[VAR_W-1:0] & mask_full[VAR_W-1:0];

  assign gen_last = (gen_idx_q == IDX_W'(NUM_VARS - 1));
  assign chk_last = (lat_cnt_q == LAT_W'(CHK_LAT - 1));
  assign last_sol = ((sol_idx_q + 16'd1) == req_count_q);

  for (genvar i = 0; i < NUM_VARS; i++) begin : g_flat
    assign cand_flat[i*VAR_W +: VAR_W] = cand_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (req_count == 16'd0) ? DONE : GEN;
        end
      end
      GEN: begin
        if (gen_last) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (chk_last) begin
          if (chk_x) begin
            state_d = EMIT;
          end else if (sol_tries_q == TRY_W'(MAX_TRIES - 1)) begin
            state_d = FAIL;
          end else begin
            state_d = GEN;
          end
        end
      end
      EMIT: begin
        if (sol_ready) begin
          state_d = last_sol ? DONE : GEN;
        end
      end
      DONE, FAIL: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and counters; cand slots are only ever written while generating.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_idx_q   <= '0;
      lat_cnt_q   <= '0;
      sol_tries_q <= '0;
      req_count_q <= '0;
      sol_idx_q   <= '0;
      tries_q     <= '0;
      sol_vars_q  <= '0;
      for (int i = 0; i < NUM_VARS; i++) begin
        cand_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            req_count_q <= req_count;
            sol_idx_q   <= '0;
            tries_q     <= '0;
            sol_tries_q <= '0;
            gen_idx_q   <= '0;
            lat_cnt_q   <= '0;
          end
        end
        GEN: begin
          cand_q[gen_idx_q] <= gen_word;
          gen_idx_q         <= gen_last ? '0 : gen_idx_q + IDX_W'(1);
          lat_cnt_q         <= '0;
        end
        CHECK: begin
          if (chk_last) begin
            lat_cnt_q <= '0;
            if (tries_q != 32'hFFFF_FFFF) begin
              tries_q <= tries_q + 32'd1;
            end
            if (chk_x) begin
              sol_vars_q <= cand_flat;
            end else begin
              sol_tries_q <= sol_tries_q + TRY_W'(1);
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        EMIT: begin
          if (sol_ready) begin
            sol_idx_q   <= sol_idx_q + 16'd1;
            sol_tries_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cand_vars  = cand_flat;
  assign cand_valid = (state_q == CHECK);
  assign sol_valid  = (state_q == EMIT);
  assign sol_vars   = sol_vars_q;
  assign sol_idx    = sol_idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign fail       = (state_q == FAIL);
  assign tries      = tries_q;

endmodule
